// File: rtl/pc_ir_unit.sv
// pc_ir_unit
// Program-counter / instruction-register stage of the multicycle datapath.
// Holds PC, IR and the ALUOut pipeline register, resolves conditional PC
// loads against the live ALU flags, and keeps fetch / taken-branch counters.
//
// Ports
//   Clk, Reset             clock, synchronous active-high reset
//   PCWrite, PCWriteCond   unconditional / conditional PC load strobes
//   BranchCond[1:0]        00 Z, 01 !Z, 10 N, 11 always
//   PCSource[1:0]          00 ALUResult, 01 ALUOut, 10 jump target, 11 illegal
//   IRWrite, MemData       instruction register load
//   ALUResult, ALUZero,    live ALU result and flags
//   ALUNeg
//   PC, OpCode, Rs, Rt,    current PC and instruction field decodes
//   Rd, ImmSE, ImmZE
//   ALUOut                 ALUResult delayed by one edge
//   BranchTaken            pulse after a taken conditional load
//   BadPCSel               sticky flag for a PC load with PCSource = 11
//   InstrCount, TakenCount IR loads (wrapping), taken branches (saturating)
module pc_ir_unit #(
    parameter int              IW       = 32,
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          PCWrite,
    input  logic          PCWriteCond,
    input  logic [1:0]    BranchCond,
    input  logic [1:0]    PCSource,
    input  logic          IRWrite,
    input  logic [IW-1:0] MemData,
    input  logic [AW-1:0] ALUResult,
    input  logic          ALUZero,
    input  logic          ALUNeg,
    output logic [AW-1:0] PC,
    output logic [5:0]    OpCode,
    output logic [4:0]    Rs,
    output logic [4:0]    Rt,
    output logic [4:0]    Rd,
    output logic [AW-1:0] ImmSE,
    output logic [AW-1:0] ImmZE,
    output logic [AW-1:0] ALUOut,
    output logic          BranchTaken,
    output logic          BadPCSel,
    output logic [CW-1:0] InstrCount,
    output logic [CW-1:0] TakenCount
);

    logic [AW-1:0] PC_q, PC_d;
    logic [IW-1:0] IR_q, IR_d;
    logic [AW-1:0] ALUOut_q;
    logic          BranchTaken_q, BranchTaken_d;
    logic          BadPCSel_q, BadPCSel_d;
    logic [CW-1:0] InstrCount_q, InstrCount_d;
    logic [CW-1:0] TakenCount_q, TakenCount_d;

    logic cond_true;
    logic pc_load;
    logic cond_taken;

    always_comb begin
        cond_true = 1'b0;
        case (BranchCond)
            2'b00:   cond_true = ALUZero;
            2'b01:   cond_true = ~ALUZero;
            2'b10:   cond_true = ALUNeg;
            default: cond_true = 1'b1;
        endcase
    end

    assign pc_load = PCWrite | (PCWriteCond & cond_true);
    // An unconditional load masks the branch pulse; an illegal source never counts as taken.
    assign cond_taken = PCWriteCond & cond_true & ~PCWrite & (PCSource != 2'b11);

    always_comb begin
        PC_d          = PC_q;
        BadPCSel_d    = BadPCSel_q;
        IR_d          = IR_q;
        InstrCount_d  = InstrCount_q;
        TakenCount_d  = TakenCount_q;
        BranchTaken_d = cond_taken;

        if (pc_load) begin
            case (PCSource)
                2'b00:   PC_d = ALUResult;
                2'b01:   PC_d = ALUOut_q;
                2'b10:   PC_d = IR_q[AW-1:0];
                default: BadPCSel_d = 1'b1;
            endcase
        end

        if (IRWrite) begin
            IR_d         = MemData;
            InstrCount_d = InstrCount_q + CW'(1);
        end

        if (cond_taken && (TakenCount_q != '1)) begin
            TakenCount_d = TakenCount_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC_q          <= RESET_PC;
            IR_q          <= '0;
            ALUOut_q      <= '0;
            BranchTaken_q <= 1'b0;
            BadPCSel_q    <= 1'b0;
            InstrCount_q  <= '0;
            TakenCount_q  <= '0;
        end else begin
            PC_q          <= PC_d;
            IR_q          <= IR_d;
            ALUOut_q      <= ALUResult;
            BranchTaken_q <= BranchTaken_d;
            BadPCSel_q    <= BadPCSel_d;
            InstrCount_q  <= InstrCount_d;
            TakenCount_q  <= TakenCount_d;
        end
    end

    // Immediate field: extend when AW is wider than 16, truncate when narrower.
    generate
        if (AW > 16) begin : g_imm_wide
            assign ImmSE = {{(AW-16){IR_q[15]}}, IR_q[15:0]};
            assign ImmZE = {{(AW-16){1'b0}}, IR_q[15:0]};
        end else begin : g_imm_narrow
            assign ImmSE = IR_q[AW-1:0];
            assign ImmZE = IR_q[AW-1:0];
        end
    endgenerate

    assign PC          = PC_q;
    assign OpCode      = IR_q[IW-1:IW-6];
    assign Rs          = IR_q[25:21];
    assign Rt          = IR_q[20:16];
    assign Rd          = IR_q[15:11];
    assign ALUOut      = ALUOut_q;
    assign BranchTaken = BranchTaken_q;
    assign BadPCSel    = BadPCSel_q;
    assign InstrCount  = InstrCount_q;
    assign TakenCount  = TakenCount_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the stage.
module tb_pc_ir_unit;

    localparam int IW = 32;
    localparam int AW = 16;
    localparam int CW = 4;
    localparam logic [15:0] RST_PC = 16'h0100;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          PCWrite, PCWriteCond, IRWrite, ALUZero, ALUNeg;
    logic [1:0]    BranchCond, PCSource;
    logic [31:0]   MemData;
    logic [15:0]   ALUResult;
    logic [15:0]   PC, ImmSE, ImmZE, ALUOut;
    logic [5:0]    OpCode;
    logic [4:0]    Rs, Rt, Rd;
    logic          BranchTaken, BadPCSel;
    logic [CW-1:0] InstrCount, TakenCount;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    int m_pc, m_ir_hi, m_aluout, m_ic, m_tc;
    logic [31:0] m_ir;
    bit m_bt, m_bad;

    always #5 Clk = ~Clk;

    pc_ir_unit #(.IW(IW), .AW(AW), .RESET_PC(RST_PC), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .BranchCond(BranchCond), .PCSource(PCSource), .IRWrite(IRWrite),
        .MemData(MemData), .ALUResult(ALUResult), .ALUZero(ALUZero), .ALUNeg(ALUNeg),
        .PC(PC), .OpCode(OpCode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .ImmSE(ImmSE),
        .ImmZE(ImmZE), .ALUOut(ALUOut), .BranchTaken(BranchTaken),
        .BadPCSel(BadPCSel), .InstrCount(InstrCount), .TakenCount(TakenCount)
    );

    task automatic idle();
        Reset = 0; PCWrite = 0; PCWriteCond = 0; IRWrite = 0;
        BranchCond = 0; PCSource = 0; MemData = 0; ALUResult = 0;
        ALUZero = 0; ALUNeg = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic step();
        bit cond, load, taken;
        int new_pc;
        if (Reset) begin
            m_pc = RST_PC; m_ir = 0; m_aluout = 0; m_bt = 0; m_bad = 0; m_ic = 0; m_tc = 0;
        end else begin
            cond  = (BranchCond == 0) ? ALUZero : (BranchCond == 1) ? !ALUZero :
                    (BranchCond == 2) ? ALUNeg : 1'b1;
            load  = PCWrite || (PCWriteCond && cond);
            taken = PCWriteCond && cond && !PCWrite && PCSource != 3;
            new_pc = m_pc;
            if (load) begin
                if (PCSource == 0) new_pc = ALUResult;
                else if (PCSource == 1) new_pc = m_aluout;
                else if (PCSource == 2) new_pc = m_ir % 65536;
                else m_bad = 1;
            end
            m_pc = new_pc;
            if (IRWrite) begin
                m_ir = MemData;
                m_ic = (m_ic + 1) % (1 << CW);
            end
            if (taken && m_tc < (1 << CW) - 1) m_tc = m_tc + 1;
            m_bt = taken;
            m_aluout = ALUResult;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1; PCWrite = 1; IRWrite = 1; MemData = 32'hFFFF_FFFF; ALUResult = 16'h1234;
        step(); step();
        idle();
        step();
        tests++;
        if (PC !== 16'h0100 || OpCode !== 6'd0 || ALUOut !== 16'h0 || InstrCount !== 4'd0 ||
            TakenCount !== 4'd0 || BadPCSel !== 1'b0 || BranchTaken !== 1'b0) begin
            fails++;
            $display("FAIL reset: PC=%h Op=%h ALUOut=%h IC=%0d TC=%0d Bad=%b BT=%b, want 0100 0 0 0 0 0 0",
                     PC, OpCode, ALUOut, InstrCount, TakenCount, BadPCSel, BranchTaken);
        end
    endtask

    task automatic test_fetch();
        idle();
        MemData = 32'h0422_1800; ALUResult = 16'h0101; IRWrite = 1; PCWrite = 1;
        step();
        idle();
        tests++;
        if (PC !== 16'h0101 || OpCode !== 6'd1 || Rs !== 5'd1 || Rt !== 5'd2 || Rd !== 5'd3 ||
            InstrCount !== 4'd1 || ImmZE !== 16'h1800) begin
            fails++;
            $display("FAIL fetch: PC=%h Op=%0d Rs=%0d Rt=%0d Rd=%0d IC=%0d Imm=%h, want 0101 1 1 2 3 1 1800",
                     PC, OpCode, Rs, Rt, Rd, InstrCount, ImmZE);
        end
    endtask

    task automatic test_jump();
        idle();
        MemData = 32'h0400_00A5; IRWrite = 1;
        step();
        idle();
        PCWrite = 1; PCSource = 2'b10;
        step();
        idle();
        tests++;
        if (PC !== 16'h00A5 || BranchTaken !== 1'b0) begin
            fails++;
            $display("FAIL jump: PC=%h BT=%b, want 00a5 0", PC, BranchTaken);
        end
    endtask

    task automatic test_cond_branch();
        idle();
        ALUResult = 16'h0200;
        step();
        PCWriteCond = 1; BranchCond = 2'b01; PCSource = 2'b01; ALUZero = 1;
        step();
        tests++;
        if (PC !== 16'h00A5 || BranchTaken !== 1'b0 || TakenCount !== 4'd0) begin
            fails++;
            $display("FAIL branch_not_taken: PC=%h BT=%b TC=%0d, want 00a5 0 0", PC, BranchTaken, TakenCount);
        end
        ALUZero = 0;
        step();
        idle();
        tests++;
        if (PC !== 16'h0200 || BranchTaken !== 1'b1 || TakenCount !== 4'd1) begin
            fails++;
            $display("FAIL branch_taken: PC=%h BT=%b TC=%0d, want 0200 1 1", PC, BranchTaken, TakenCount);
        end
        step();
        tests++;
        if (BranchTaken !== 1'b0) begin
            fails++;
            $display("FAIL branch_pulse_width: BT=%b, want 0", BranchTaken);
        end
    endtask

    task automatic test_both_writes();
        idle();
        PCWrite = 1; PCWriteCond = 1; ALUZero = 1; BranchCond = 2'b01; ALUResult = 16'h0333;
        step();
        tests++;
        if (PC !== 16'h0333 || BranchTaken !== 1'b0) begin
            fails++;
            $display("FAIL both_cond_false: PC=%h BT=%b, want 0333 0", PC, BranchTaken);
        end
        ALUZero = 0; ALUResult = 16'h0444;
        step();
        idle();
        tests++;
        if (PC !== 16'h0444 || BranchTaken !== 1'b0 || TakenCount !== 4'd1) begin
            fails++;
            $display("FAIL both_cond_true: PC=%h BT=%b TC=%0d, want 0444 0 1", PC, BranchTaken, TakenCount);
        end
    endtask

    task automatic test_bad_sel();
        idle();
        PCWrite = 1; PCSource = 2'b11; ALUResult = 16'h0777;
        step();
        idle();
        tests++;
        if (PC !== 16'h0444 || BadPCSel !== 1'b1) begin
            fails++;
            $display("FAIL bad_sel: PC=%h Bad=%b, want 0444 1", PC, BadPCSel);
        end
        PCWrite = 1; ALUResult = 16'h0555;
        step(); step();
        idle();
        tests++;
        if (PC !== 16'h0555 || BadPCSel !== 1'b1) begin
            fails++;
            $display("FAIL bad_sel_sticky: PC=%h Bad=%b, want 0555 1", PC, BadPCSel);
        end
        Reset = 1; IRWrite = 1; MemData = 32'hFC00_0001; PCWrite = 1; ALUResult = 16'h0999;
        step();
        idle();
        tests++;
        if (OpCode !== 6'd0 || ImmZE !== 16'h0 || InstrCount !== 4'd0 || PC !== 16'h0100 || BadPCSel !== 1'b0) begin
            fails++;
            $display("FAIL reset_over_load: Op=%0d Imm=%h IC=%0d PC=%h Bad=%b, want 0 0 0 0100 0",
                     OpCode, ImmZE, InstrCount, PC, BadPCSel);
        end
    endtask

    task automatic test_counter_bounds();
        idle();
        Reset = 1;
        step();
        idle();
        IRWrite = 1; PCWriteCond = 1; BranchCond = 2'b11; PCSource = 2'b00;
        for (int i = 0; i < 16; i++) begin
            MemData = $urandom; ALUResult = 16'($urandom);
            step();
        end
        tests++;
        if (InstrCount !== 4'd0 || TakenCount !== 4'hF) begin
            fails++;
            $display("FAIL counter_bounds: IC=%0d TC=%0d, want 0 15", InstrCount, TakenCount);
        end
        step();
        idle();
        tests++;
        if (InstrCount !== 4'd1 || TakenCount !== 4'hF || BranchTaken !== 1'b1) begin
            fails++;
            $display("FAIL counter_wrap_sat: IC=%0d TC=%0d BT=%b, want 1 15 1", InstrCount, TakenCount, BranchTaken);
        end
    endtask

    task automatic test_random();
        int imm;
        for (int n = 0; n < 400; n++) begin
            Reset       = ($urandom_range(0, 49) == 0);
            PCWrite     = ($urandom_range(0, 3) == 0);
            PCWriteCond = ($urandom_range(0, 2) == 0);
            BranchCond  = 2'($urandom);
            PCSource    = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            IRWrite     = $urandom_range(0, 1);
            MemData     = $urandom;
            ALUResult   = 16'($urandom);
            ALUZero     = $urandom_range(0, 1);
            ALUNeg      = $urandom_range(0, 1);
            step();
            imm = m_ir % 65536;
            tests++;
            if (PC !== 16'(m_pc) || ALUOut !== 16'(m_aluout) || BranchTaken !== m_bt ||
                BadPCSel !== m_bad || InstrCount !== 4'(m_ic) || TakenCount !== 4'(m_tc)) begin
                fails++;
                $display("FAIL random_regs[%0d]: PC=%h ALUOut=%h BT=%b Bad=%b IC=%0d TC=%0d, want %h %h %b %b %0d %0d",
                         n, PC, ALUOut, BranchTaken, BadPCSel, InstrCount, TakenCount,
                         16'(m_pc), 16'(m_aluout), m_bt, m_bad, m_ic, m_tc);
            end
            tests++;
            if (OpCode !== 6'(m_ir / 67108864) || Rs !== 5'((m_ir / 2097152) % 32) ||
                Rt !== 5'((m_ir / 65536) % 32) || Rd !== 5'((m_ir / 2048) % 32) ||
                ImmSE !== 16'(imm) || ImmZE !== 16'(imm)) begin
                fails++;
                $display("FAIL random_decode[%0d]: Op=%0d Rs=%0d Rt=%0d Rd=%0d SE=%h ZE=%h, IR model %h",
                         n, OpCode, Rs, Rt, Rd, ImmSE, ImmZE, m_ir);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fetch();
        test_jump();
        test_cond_branch();
        test_both_writes();
        test_bad_sel();
        test_counter_bounds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
